// File: rtl/freq_divider_prog_multi.sv
// Multi-channel programmable clock divider with 50% duty for odd and even N.
// Per-channel enable, boundary-safe divisor reload, shared phase re-sync.
module freq_divider_prog_multi #(
    parameter int NCH = 4,
    parameter int W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     en,
    input  logic [NCH*W-1:0]   div,
    input  logic               sync,
    output logic [NCH-1:0]     clk_out,
    output logic [NCH-1:0]     tick
);

    logic [NCH-1:0][W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0][W-1:0] cur_div_q, cur_div_d;
    logic [NCH-1:0][W-1:0] div_clamp;
    logic [NCH-1:0]        q_pos_q, q_pos_d;
    logic [NCH-1:0]        q_neg_q, q_neg_d;
    logic [NCH-1:0]        tick_q, tick_d;
    logic [NCH-1:0]        en_q;
    logic [NCH-1:0]        restart;
    logic [NCH-1:0][W-1:0] cnt_inc;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            div_clamp[i] = div[i*W +: W];
            if (div[i*W +: W] < W'(2)) begin
                div_clamp[i] = W'(2);
            end
        end
    end

    // start, sync and wrap all collapse to the same reload action
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_inc[i] = cnt_q[i] + W'(1);
            restart[i] = (en[i] & ~en_q[i]) | sync
                       | (cnt_q[i] == cur_div_q[i] - W'(1));
            cnt_d[i]     = cnt_q[i];
            cur_div_d[i] = cur_div_q[i];
            q_pos_d[i]   = 1'b0;
            tick_d[i]    = 1'b0;
            if (!en[i]) begin
                cnt_d[i] = '0;
            end else if (restart[i]) begin
                cnt_d[i]     = '0;
                cur_div_d[i] = div_clamp[i];
                q_pos_d[i]   = 1'b1;
                tick_d[i]    = 1'b1;
            end else begin
                cnt_d[i]   = cnt_inc[i];
                q_pos_d[i] = cnt_inc[i] < {1'b0, cur_div_q[i][W-1:1]};
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            q_neg_d[i] = q_pos_q[i] & cur_div_q[i][0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            cur_div_q <= '0;
            q_pos_q   <= '0;
            tick_q    <= '0;
            en_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
            q_pos_q   <= q_pos_d;
            tick_q    <= tick_d;
            en_q      <= en;
        end
    end

    // half-cycle extension of the high phase for odd divisors
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            q_neg_q <= '0;
        end else begin
            q_neg_q <= q_neg_d;
        end
    end

    assign clk_out = q_pos_q | q_neg_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_freq_divider_prog_multi.sv
// Directed self-checking bench for freq_divider_prog_multi.
// Expected waveforms come from a period/phase model of the divider.
module tb_freq_divider_prog_multi;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic             clk;
    logic             rst;
    logic [NCH-1:0]   en;
    logic [NCH*W-1:0] div;
    logic             sync;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;

    int checks;
    int errors;

    freq_divider_prog_multi #(.NCH(NCH), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div     (div),
        .sync    (sync),
        .clk_out (clk_out),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // k = phase of the period at the checked posedge; n=0 skips a channel.
    // After a posedge the output is high for k < ceil(n/2),
    // after the following negedge for k < floor(n/2).
    task automatic run(input int n0, input int k0, input int n1,
                       input int k1, input int cycles);
        int k;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (n0 != 0) begin
                k = (k0 + i) % n0;
                check("ch0_pos", 32'(clk_out[0]), 32'(k < (n0 + 1) / 2));
                check("ch0_tick", 32'(tick[0]), 32'(k == 0));
            end
            if (n1 != 0) begin
                k = (k1 + i) % n1;
                check("ch1_pos", 32'(clk_out[1]), 32'(k < (n1 + 1) / 2));
                check("ch1_tick", 32'(tick[1]), 32'(k == 0));
            end
            @(negedge clk); #1;
            if (n0 != 0) begin
                k = (k0 + i) % n0;
                check("ch0_neg", 32'(clk_out[0]), 32'(k < n0 / 2));
            end
            if (n1 != 0) begin
                k = (k1 + i) % n1;
                check("ch1_neg", 32'(clk_out[1]), 32'(k < n1 / 2));
            end
        end
    endtask

    task automatic set_div(input int ch, input int val);
        div[ch*W +: W] = W'(val);
    endtask

    task automatic all_off();
        en = '0;
        @(posedge clk); #1;
        @(negedge clk); #1;
        check("off_clk", 32'(clk_out), 32'd0);
        check("off_tick", 32'(tick), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        en   = '0;
        div  = '0;
        sync = 1'b0;
        #1;
        check("rst_clk", 32'(clk_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        @(negedge clk); #2;
        rst = 1'b0;
        @(negedge clk); #1;
        check("idle_clk", 32'(clk_out), 32'd0);

        set_div(0, 4);
        en[0] = 1'b1;
        run(4, 0, 0, 0, 8);

        set_div(1, 5);
        en[1] = 1'b1;
        run(0, 0, 5, 0, 10);

        all_off();
        en[0] = 1'b1;
        run(4, 0, 0, 0, 2);
        set_div(0, 6);
        run(4, 2, 0, 0, 2);
        run(6, 0, 0, 0, 12);

        all_off();
        set_div(0, 0);
        set_div(1, 1);
        en[1:0] = 2'b11;
        run(2, 0, 2, 0, 6);

        all_off();
        set_div(0, 4);
        set_div(1, 6);
        en[1:0] = 2'b11;
        run(4, 0, 6, 0, 5);
        sync = 1'b1;
        run(4, 0, 6, 0, 1);
        sync = 1'b0;
        check("sync_off_ch", 32'(clk_out[3:2]), 32'd0);
        check("sync_off_tk", 32'(tick[3:2]), 32'd0);
        run(4, 1, 6, 1, 8);

        check("pre_rst_hi", 32'(clk_out[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_clk", 32'(clk_out), 32'd0);
        check("arst_tick", 32'(tick), 32'd0);
        #1;
        rst = 1'b0;
        run(4, 0, 6, 0, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
